// File: rtl/img_pkg.sv
// Shared pixel types and binary output levels for the img_bg thresholding block.
// Used by img_raster_cnt and img_bg.
package img_pkg;

    localparam int         PIX_W    = 8;
    localparam logic [7:0] BW_WHITE = 8'hFF;
    localparam logic [7:0] BW_BLACK = 8'h00;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/img_raster_cnt.sv
// Raster column/row counter for a W x H frame with wrap and last-pixel flag.
// o_x/o_y give the position of the next accepted pixel.
import img_pkg::*;

module img_raster_cnt #(
    parameter  int W  = 256,
    parameter  int H  = 256,
    localparam int XW = $clog2(W),
    localparam int YW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last = (r_x == XW'(W - 1));
    assign w_y_last = (r_y == YW'(H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_last && w_y_last;

endmodule

// File: rtl/img_bg.sv
// Streaming grayscale to black/white thresholder with raster position tracking.
// Define IMG_BG_AUTO_THRESH_EN to threshold each frame at the previous frame's mean.
import img_pkg::*;

module img_bg #(
    parameter  int   W          = 256,
    parameter  int   H          = 256,
    parameter  pix_t DEF_THRESH = 8'd128,
    localparam int   XW         = $clog2(W),
    localparam int   YW         = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  pix_t          pixel_in,
    input  logic          pixel_valid,
    input  pix_t          threshold,
    output pix_t          bw_out,
    output logic          bw_valid,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          frame_done
);

    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_last;
    pix_t          w_thr;

    img_raster_cnt #(
        .W (W),
        .H (H)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (pixel_valid),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

`ifdef IMG_BG_AUTO_THRESH_EN
    localparam int LOG_N = $clog2(W * H);
    localparam int ACC_W = PIX_W + LOG_N;

    logic [ACC_W-1:0] r_acc;
    pix_t             r_thr;
    logic [ACC_W-1:0] w_sum;
    logic             w_unused_thr;

    assign w_sum        = r_acc + ACC_W'(pixel_in);
    assign w_thr        = r_thr;
    assign w_unused_thr = ^threshold;

    // Mean includes the last pixel; it takes effect from the next frame's (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_thr <= DEF_THRESH;
        end else if (pixel_valid) begin
            if (w_last) begin
                r_acc <= '0;
                r_thr <= w_sum[ACC_W-1:LOG_N];
            end else begin
                r_acc <= w_sum;
            end
        end
    end
`else
    assign w_thr = threshold;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bw_out     <= BW_BLACK;
            bw_valid   <= 1'b0;
            x_pos      <= '0;
            y_pos      <= '0;
            frame_done <= 1'b0;
        end else begin
            bw_valid   <= pixel_valid;
            frame_done <= pixel_valid && w_last;
            if (pixel_valid) begin
                bw_out <= (pixel_in >= w_thr) ? BW_WHITE : BW_BLACK;
                x_pos  <= w_x;
                y_pos  <= w_y;
            end
        end
    end

endmodule

// File: tb/tb_img_bg.sv
// Self-checking bench for img_bg at W = H = 4: vector table plus scoreboard.
// Also covers the auto-threshold build when IMG_BG_AUTO_THRESH_EN is defined.
`timescale 1ns/1ps

module tb_img_bg;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic       pixel_valid = 1'b0;
    logic [7:0] threshold = 8'd128;
    logic [7:0] bw_out;
    logic       bw_valid;
    logic [1:0] x_pos;
    logic [1:0] y_pos;
    logic       frame_done;

    img_bg #(
        .W          (W),
        .H          (H),
        .DEF_THRESH (8'd128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .threshold   (threshold),
        .bw_out      (bw_out),
        .bw_valid    (bw_valid),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bw;
        int         x;
        int         y;
        logic       done;
    } exp_t;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] thr;
        logic [7:0] exp;
    } vec_t;

    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_pulse = 0;
    int         n_done = 0;
    logic [7:0] last_bw = 8'h00;

    // reference model state
    int         mx = 0;
    int         my = 0;
    int         m_acc = 0;
    logic [7:0] m_thr = 8'd128;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        mx      = 0;
        my      = 0;
        m_acc   = 0;
        m_thr   = 8'd128;
        last_bw = 8'h00;
    endtask

    task automatic drive(input logic v, input logic [7:0] p, input logic [7:0] t,
                         input logic use_e = 1'b0, input logic [7:0] e = 8'h00);
        exp_t       r;
        logic [7:0] act;
        logic       last;
        @(negedge clk);
        pixel_valid = v;
        pixel_in    = p;
        threshold   = t;
        if (v) begin
            last = (mx == W - 1) && (my == H - 1);
`ifdef IMG_BG_AUTO_THRESH_EN
            act   = m_thr;
            m_acc = m_acc + int'(p);
            if (last) begin
                m_thr = 8'(m_acc >> 4);
                m_acc = 0;
            end
`else
            act = t;
`endif
            r.bw   = use_e ? e : ((p >= act) ? 8'hFF : 8'h00);
            r.x    = mx;
            r.y    = my;
            r.done = last;
            sbq.push_back(r);
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'd128);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'hFF;
        threshold   = 8'd128;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bw_out", bw_out, 8'h00);
        chk("rst_bw_valid", bw_valid, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_done", frame_done, 0);
        model_reset();
        @(negedge clk);
        pixel_valid = 1'b0;
        rst         = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bw_valid) begin
                n_pulse++;
                if (frame_done) n_done++;
                if (sbq.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("bw_out", bw_out, e.bw);
                    chk("x_pos", x_pos, e.x);
                    chk("y_pos", y_pos, e.y);
                    chk("frame_done", frame_done, e.done);
                end
                last_bw = bw_out;
            end else begin
                chk("idle_hold_bw", bw_out, last_bw);
                chk("idle_done", frame_done, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{8'h7F, 8'd128, 8'h00};
        tbl[1] = '{8'h80, 8'd128, 8'hFF};
        tbl[2] = '{8'h00, 8'd128, 8'h00};
        tbl[3] = '{8'hFF, 8'd128, 8'hFF};
        tbl[4] = '{8'h00, 8'd0,   8'hFF};
        tbl[5] = '{8'hFE, 8'd255, 8'h00};
        tbl[6] = '{8'hFF, 8'd255, 8'hFF};

        // reset with a white pixel held on the input, then first pixel at (0,0)
        do_reset();
        drive(1'b1, 8'hFF, 8'd128, 1'b1, 8'hFF);

`ifndef IMG_BG_AUTO_THRESH_EN
        for (int i = 0; i < 7; i++)
            drive(1'b1, tbl[i].pix, tbl[i].thr, 1'b1, tbl[i].exp);
`endif

        // finish the frame continuously, then pixel 17 must wrap to (0,0)
        while (!(mx == 0 && my == 0))
            drive(1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)));
        drive(1'b1, 8'h10, 8'h20);
        idle(2);

        // mid-frame reset after 5 pixels
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hFF, 8'd0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", bw_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_bw_out", bw_out, 8'h00);
        chk("async_valid", bw_valid, 0);
        chk("async_y", y_pos, 0);
        model_reset();
        @(negedge clk);
        rst         = 1'b0;
        pixel_valid = 1'b0;
        drive(1'b1, 8'h90, 8'd128);
        idle(2);

        // gapped frame: 16 pulses, one frame_done
        do_reset();
        n_pulse = 0;
        n_done  = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)));
            drive(1'b0, 8'h00, 8'd128);
        end
        idle(2);
        chk("gap_pulses", n_pulse, 16);
        chk("gap_done_count", n_done, 1);

`ifdef IMG_BG_AUTO_THRESH_EN
        do_reset();
        for (int i = 0; i < 16; i++)
            drive(1'b1, 8'h40, 8'h00, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) drive(1'b1, 8'h3F, 8'hFF, 1'b1, 8'h00);
            else            drive(1'b1, 8'h40, 8'hFF, 1'b1, 8'hFF);
        end
        idle(2);
`endif

        chk("queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
